// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core_p processor: opcodes, FSM state codes
// and the instruction word layout.
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'd0;
    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_XOR  = 6'd5;
    localparam logic [5:0] OP_LDI  = 6'd6;
    localparam logic [5:0] OP_ST   = 6'd7;
    localparam logic [5:0] OP_LD   = 6'd8;
    localparam logic [5:0] OP_JMP  = 6'd9;
    localparam logic [5:0] OP_BRF  = 6'd10;
    localparam logic [5:0] OP_HALT = 6'd11;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_MEM   = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    // Packed MSB-first: imm[31:16], hl[15], rd[14:12], rb[11:9], ra[8:6], op[5:0].
    typedef struct packed {
        logic [15:0] imm;
        logic        hl;
        logic [2:0]  rd;
        logic [2:0]  rb;
        logic [2:0]  ra;
        logic [5:0]  op;
    } instr_t;

endpackage

// File: rtl/cpu_core_p_if.sv
// Memory port of cpu_core_p: single request/acknowledge channel shared by
// instruction fetch, loads and stores.
interface cpu_core_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/cpu_regfile.sv
// Eight DATA_W-bit registers with a 1-bit flag each: two asynchronous read
// ports, one synchronous write port, asynchronous active-low clear.
module cpu_regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [2:0]        ra_addr,
    input  logic [2:0]        rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_flag,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic              flag_data
);
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic [7:0]        flags_q;
    logic [7:0]        flags_d;

    assign ra_data = regs_q[ra_addr];
    assign rb_data = regs_q[rb_addr];
    assign ra_flag = flags_q[ra_addr];

    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        if (wr_en)   regs_d[wr_addr]  = wr_data;
        if (flag_we) flags_d[wr_addr] = flag_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end
endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle FETCH/EXEC/MEM processor core with a single shared memory port
// and an eight-entry register file.
module cpu_core_p
    import cpu_pkg::*;
#(
    parameter int              DATA_W   = 32,
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    cpu_core_p_if.master      mem,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);
    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            ir_q, ir_d;
    logic              illegal_q, illegal_d;
    logic              run_q, run_d;

    logic [DATA_W-1:0] ra_data, rb_data;
    logic              ra_flag;
    logic [2:0]        ra_sel;
    logic              wr_en, flag_we, flag_data;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] logic_res, ldi_hi;
    logic [ADDR_W-1:0] pc_inc, imm_sext;
    logic              req;

    // LDI with hl=1 must keep rd's other bits, so port A reads rd for LDI.
    assign ra_sel = (ir_q.op == OP_LDI) ? ir_q.rd : ir_q.ra;

    cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .ra_addr   (ra_sel),
        .rb_addr   (ir_q.rb),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .ra_flag   (ra_flag),
        .wr_en     (wr_en),
        .wr_addr   (ir_q.rd),
        .wr_data   (wr_data),
        .flag_we   (flag_we),
        .flag_data (flag_data)
    );

    // run_q keeps mem_req low until the first clock edge after reset release.
    assign req           = run_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
    assign mem.mem_req   = req;
    assign mem.mem_we    = (state_q == ST_MEM) && (ir_q.op == OP_ST);
    assign mem.mem_addr  = (state_q == ST_FETCH) ? pc_q :
                           (ir_q.op == OP_ST)    ? ADDR_W'(rb_data) : ADDR_W'(ra_data);
    assign mem.mem_wdata = ra_data;

    assign pc      = pc_q;
    assign halted  = (state_q == ST_HALT);
    assign illegal = illegal_q;

    always_comb begin
        sum      = {1'b0, ra_data} + {1'b0, rb_data};
        diff     = {1'b0, ra_data} - {1'b0, rb_data};
        pc_inc   = pc_q + ADDR_W'(1);
        imm_sext = ADDR_W'(signed'(ir_q.imm));
        ldi_hi   = ra_data;
        ldi_hi[31:16] = ir_q.imm;
        case (ir_q.op)
            OP_AND:  logic_res = ra_data & rb_data;
            OP_OR:   logic_res = ra_data | rb_data;
            default: logic_res = ra_data ^ rb_data;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        run_d     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = '0;
        flag_we   = 1'b0;
        flag_data = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (req && mem.mem_ack) begin
                    ir_d    = instr_t'(mem.mem_rdata[31:0]);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_inc;
                case (ir_q.op)
                    OP_NOP: ;
                    OP_ADD: begin
                        wr_en     = 1'b1;
                        wr_data   = sum[DATA_W-1:0];
                        flag_we   = 1'b1;
                        flag_data = sum[DATA_W];
                    end
                    OP_SUB: begin
                        wr_en     = 1'b1;
                        wr_data   = diff[DATA_W-1:0];
                        flag_we   = 1'b1;
                        flag_data = diff[DATA_W];
                    end
                    OP_AND, OP_OR, OP_XOR: begin
                        wr_en     = 1'b1;
                        wr_data   = logic_res;
                        flag_we   = 1'b1;
                        flag_data = (logic_res == '0);
                    end
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = ir_q.hl ? ldi_hi : DATA_W'(ir_q.imm);
                    end
                    OP_ST, OP_LD: begin
                        state_d = ST_MEM;
                        pc_d    = pc_q;
                    end
                    OP_JMP:  pc_d = ADDR_W'(ra_data);
                    OP_BRF:  if (ra_flag) pc_d = pc_q + imm_sext;
                    OP_HALT: begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            ST_MEM: begin
                if (req && mem.mem_ack) begin
                    state_d = ST_FETCH;
                    pc_d    = pc_inc;
                    if (ir_q.op == OP_LD) begin
                        wr_en   = 1'b1;
                        wr_data = mem.mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            run_q     <= run_d;
        end
    end
endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p: directed programs, expected memory
// transactions queued up front and checked by an independent monitor.
module tb_cpu_core_p;
    import cpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } txn_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              illegal;

    logic [31:0] mem [256];
    int          ack_delay = 1;
    int          wait_cnt  = 0;
    txn_t        exp_q [$];
    int          n_checks  = 0;
    int          n_fail    = 0;

    cpu_core_p_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    cpu_core_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC('0)) dut (
        .clock   (clock),
        .reset   (reset),
        .mem     (bus),
        .pc      (pc),
        .halted  (halted),
        .illegal (illegal)
    );

    always #5 clock = ~clock;

    // Memory model: ack after ack_delay cycles of pending request.
    assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_delay);
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    always @(posedge clock) begin
        if (bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) mem[bus.mem_addr[7:0]] = bus.mem_wdata;
            wait_cnt <= 0;
        end else if (bus.mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic hl, input logic [15:0] imm);
        return {imm, hl, rd, rb, ra, op};
    endfunction

    task automatic expFetch(input logic [ADDR_W-1:0] a);
        exp_q.push_back('{we: 1'b0, addr: a, wdata: '0});
    endtask

    task automatic expWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_q.push_back('{we: 1'b1, addr: a, wdata: d});
    endtask

    // Monitor: handshakes are popped from the scoreboard; pending requests must hold still.
    logic              pend = 1'b0;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    txn_t              got_exp;

    always @(negedge clock) begin
        if (!reset) begin
            pend = 1'b0;
        end else if (bus.mem_req) begin
            if (pend) begin
                checkOutput("hold_addr", 64'(bus.mem_addr), 64'(pend_addr));
                checkOutput("hold_we", 64'(bus.mem_we), 64'(pend_we));
                if (pend_we) checkOutput("hold_wdata", 64'(bus.mem_wdata), 64'(pend_wdata));
            end
            if (bus.mem_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_txn: got addr 0x%0h we %0d, expected no transaction",
                             bus.mem_addr, bus.mem_we);
                end else begin
                    got_exp = exp_q.pop_front();
                    checkOutput("txn_we", 64'(bus.mem_we), 64'(got_exp.we));
                    checkOutput("txn_addr", 64'(bus.mem_addr), 64'(got_exp.addr));
                    if (got_exp.we) checkOutput("txn_wdata", 64'(bus.mem_wdata), 64'(got_exp.wdata));
                end
                pend = 1'b0;
            end else begin
                pend       = 1'b1;
                pend_we    = bus.mem_we;
                pend_addr  = bus.mem_addr;
                pend_wdata = bus.mem_wdata;
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [31:0] prog [$], input int delay);
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
        ack_delay = delay;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic waitHalted(input int limit);
        int c = 0;
        while (!halted && c < limit) begin
            @(negedge clock);
            c++;
        end
        checkOutput("halt_reached", 64'(halted), 64'd1);
    endtask

    task automatic checkQuiet(input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            seen = seen | bus.mem_req;
        end
        checkOutput("req_after_halt", 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] prog [$];
        int          c;

        #1;
        checkOutput("rst_req", 64'(bus.mem_req), 64'd0);
        checkOutput("rst_pc", 64'(pc), 64'd0);
        checkOutput("rst_halted", 64'(halted), 64'd0);
        checkOutput("rst_illegal", 64'(illegal), 64'd0);

        // Program 1: arithmetic, flags, branch, illegal opcode, halt.
        prog = '{enc(OP_LDI, 1, 0, 0, 0, 16'd5),
                 enc(OP_LDI, 2, 0, 0, 0, 16'd3),
                 enc(OP_SUB, 3, 1, 2, 0, 16'd0),
                 enc(OP_LDI, 5, 0, 0, 0, 16'h40),
                 enc(OP_ST,  0, 3, 5, 0, 16'd0),
                 enc(OP_XOR, 6, 1, 1, 0, 16'd0),
                 enc(OP_BRF, 0, 6, 0, 0, 16'd2),
                 enc(OP_ST,  0, 1, 5, 0, 16'd0),
                 32'h0000_003F,
                 enc(OP_ST,  0, 1, 5, 0, 16'd0),
                 enc(OP_SUB, 2, 2, 1, 0, 16'd0),
                 enc(OP_ST,  0, 2, 5, 0, 16'd0),
                 enc(OP_BRF, 0, 3, 0, 0, 16'd5),
                 enc(OP_BRF, 0, 2, 0, 0, 16'd2),
                 enc(OP_HALT, 0, 0, 0, 0, 16'd0),
                 enc(OP_HALT, 0, 0, 0, 0, 16'd0)};
        for (int a = 0; a <= 4; a++) expFetch(ADDR_W'(a));
        expWrite(32'h40, 32'd2);
        expFetch(5); expFetch(6); expFetch(8); expFetch(9);
        expWrite(32'h40, 32'd5);
        expFetch(10); expFetch(11);
        expWrite(32'h40, 32'hFFFF_FFFE);
        expFetch(12); expFetch(13); expFetch(15);
        applyStimulus(prog, 1);
        repeat (9) @(posedge clock);
        #1 checkOutput("pc_after_2_alu", 64'(pc), 64'd2);
        @(posedge clock);
        #1 checkOutput("pc_after_3_alu", 64'(pc), 64'd3);
        waitHalted(2000);
        checkOutput("p1_pc_final", 64'(pc), 64'd15);
        checkOutput("p1_illegal", 64'(illegal), 64'd1);
        checkQuiet(10);
        checkOutput("p1_illegal_sticky", 64'(illegal), 64'd1);
        checkOutput("p1_queue_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("rst2_halted", 64'(halted), 64'd0);
        checkOutput("rst2_illegal", 64'(illegal), 64'd0);
        checkOutput("rst2_pc", 64'(pc), 64'd0);
        checkOutput("rst2_req", 64'(bus.mem_req), 64'd0);

        // Program 2: carry out, backward branch, store/load with slow memory.
        prog = '{enc(OP_LDI, 1, 0, 0, 0, 16'hFFFF),
                 enc(OP_LDI, 1, 0, 0, 1, 16'hFFFF),
                 enc(OP_LDI, 2, 0, 0, 0, 16'd1),
                 enc(OP_LDI, 5, 0, 0, 0, 16'h40),
                 enc(OP_LDI, 6, 0, 0, 0, 16'd8),
                 enc(OP_LDI, 7, 0, 0, 0, 16'd11),
                 enc(OP_JMP, 0, 6, 0, 0, 16'd0),
                 enc(OP_JMP, 0, 7, 0, 0, 16'd0),
                 enc(OP_ADD, 3, 1, 2, 0, 16'd0),
                 enc(OP_BRF, 0, 3, 0, 0, 16'hFFFE),
                 enc(OP_HALT, 0, 0, 0, 0, 16'd0),
                 enc(OP_ST,  0, 3, 5, 0, 16'd0),
                 enc(OP_ST,  0, 1, 5, 0, 16'd0),
                 enc(OP_LD,  4, 5, 0, 0, 16'd0),
                 enc(OP_ST,  0, 4, 6, 0, 16'd0),
                 enc(OP_HALT, 0, 0, 0, 0, 16'd0)};
        for (int a = 0; a <= 6; a++) expFetch(ADDR_W'(a));
        expFetch(8); expFetch(9); expFetch(7); expFetch(11);
        expWrite(32'h40, 32'h0);
        expFetch(12);
        expWrite(32'h40, 32'hFFFF_FFFF);
        expFetch(13);
        expFetch(32'h40);
        expFetch(14);
        expWrite(32'h8, 32'hFFFF_FFFF);
        expFetch(15);
        applyStimulus(prog, 3);
        waitHalted(3000);
        checkOutput("p2_pc_final", 64'(pc), 64'd15);
        checkOutput("p2_illegal", 64'(illegal), 64'd0);
        checkOutput("p2_queue_drained", 64'(exp_q.size()), 64'd0);

        // Program 3: reset while a load is waiting for its ack.
        prog = '{enc(OP_LDI, 1, 0, 0, 0, 16'd7),
                 enc(OP_LDI, 5, 0, 0, 0, 16'h40),
                 enc(OP_LD,  2, 5, 0, 0, 16'd0)};
        expFetch(0); expFetch(1); expFetch(2);
        applyStimulus(prog, 3);
        c = 0;
        while (!(bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h40) && c < 500) begin
            @(negedge clock);
            c++;
        end
        checkOutput("load_reached", 64'(c < 500), 64'd1);
        reset = 1'b0;
        #1 checkOutput("midload_req_drop", 64'(bus.mem_req), 64'd0);
        checkOutput("p3_queue_drained", 64'(exp_q.size()), 64'd0);

        prog = '{enc(OP_ST, 0, 1, 0, 0, 16'd0),
                 enc(OP_ST, 0, 5, 0, 0, 16'd0),
                 enc(OP_HALT, 0, 0, 0, 0, 16'd0)};
        expFetch(0);
        expWrite(32'h0, 32'h0);
        expFetch(1);
        expWrite(32'h0, 32'h0);
        expFetch(2);
        applyStimulus(prog, 1);
        waitHalted(1000);
        checkOutput("p4_pc_final", 64'(pc), 64'd2);
        checkOutput("p4_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_core_p.md
CPU_CORE_P -- requirements
Module: cpu_core_p

Interface
REQ-001 Parameter DATA_W, default 32, datapath and register width; legal values 32 or 64.
REQ-002 Parameter ADDR_W, default 32, word-address width of the memory port.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; assertion clears all state immediately.
REQ-006 mem_req  out  1  memory request; held high until the cycle mem_ack is sampled high.
REQ-007 mem_we  out  1  1 = write (store), 0 = read (fetch or load); valid while mem_req is high.
REQ-008 mem_addr  out  ADDR_W  word address; valid while mem_req is high.
REQ-009 mem_wdata  out  DATA_W  store data; valid while mem_req and mem_we are high.
REQ-010 mem_rdata  in  DATA_W  read data; sampled in the mem_ack cycle; instruction = mem_rdata[31:0].
REQ-011 mem_ack  in  1  completes the pending request; ignored while mem_req is low.
REQ-012 pc  out  ADDR_W  current program counter.
REQ-013 halted  out  1  high while in state HALT.
REQ-014 illegal  out  1  sticky; set by an undefined opcode and cleared only by reset.

Function
REQ-015 Instruction fields: op[5:0], ra[8:6], rb[11:9], rd[14:12], hl[15], imm[31:16]; 8 registers r0-r7 of DATA_W bits, each with a 1-bit flag.
REQ-016 States: FETCH, EXEC, MEM, HALT. FETCH->EXEC on ack; EXEC->MEM for LD/ST; EXEC->HALT for HALT; EXEC->FETCH otherwise; MEM->FETCH on ack; HALT is terminal until reset.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=pc; the instruction register loads on ack.
REQ-018 Non-memory instruction latency: fetch wait + 1 ack cycle + 1 EXEC cycle; with zero-wait memory (ack the cycle after req rises), back-to-back ALU instructions retire every 3 cycles.
REQ-019 ADD(1)/SUB(2): rd = ra +/- rb, modulo 2^DATA_W; flag[rd] = carry out (ADD) or borrow (SUB).
REQ-020 AND(3)/OR(4)/XOR(5): rd = ra op rb; flag[rd] = (result == 0).
REQ-021 LDI(6): hl=0 -> rd = zero-extended imm; hl=1 -> rd[31:16] = imm with all other bits kept; flag unchanged.
REQ-022 ST(7): MEM issues a write with mem_addr = rb[ADDR_W-1:0] and mem_wdata = ra.
REQ-023 LD(8): MEM issues a read with mem_addr = ra[ADDR_W-1:0]; rd = mem_rdata in the ack cycle.
REQ-024 JMP(9): pc = ra[ADDR_W-1:0].
REQ-025 BRF(10): if flag[ra] = 1, pc = pc + sign-extended imm; otherwise pc = pc + 1.
REQ-026 NOP(0) and HALT(11): no register write; HALT leaves pc unchanged.
REQ-027 Undefined opcodes (12-63): set illegal, execute as NOP.
REQ-028 All other instructions: pc = pc + 1 at EXEC or MEM exit; pc wraps modulo 2^ADDR_W.
REQ-029 When rd equals ra or rb, sources are read before the write; the new value is visible to the next instruction.
REQ-030 Address, data, and write-enable are held stable from request rise until ack; ack in the same cycle as request rise completes the request.

Reset
REQ-031 On reset assertion, the following take effect asynchronously: state = FETCH, pc = RESET_PC, mem_req = 0, halted = 0, illegal = 0, all registers and flags = 0, instruction register = 0.
REQ-032 Reset asserted during an outstanding request drops mem_req immediately; mem_req rises again only in the first clock after reset is released.

Structure
REQ-033 Package cpu_pkg holds the opcode constants, the state enum, and the instruction field positions.
REQ-034 One sub-module, cpu_regfile: 8 x DATA_W registers plus flags, two asynchronous read ports, one synchronous write port with flag write enable, and an async active-low clear.

Verification
REQ-035 Zero-wait memory, LDI r1,5; LDI r2,3; SUB r3,r1,r2 -> r3=2, flag3=0, pc=3 after 9 cycles.
REQ-036 ADD of 0xFFFFFFFF + 1 with DATA_W=32 -> rd=0, flag[rd]=1; BRF on that flag with imm=0xFFFE -> pc decrements by 2.
REQ-037 ST r1 -> [r2=0x40], then LD r4 <- [0x40], with 3-cycle ack delay -> mem_req and mem_addr stable throughout, r4 equals r1.
REQ-038 Opcode 0x3F -> illegal=1 and remains 1; the next instruction executes normally.
REQ-039 HALT -> halted=1, no further mem_req; reset pulse -> fetch restarts at RESET_PC.
REQ-040 Reset asserted mid-load with ack pending -> mem_req=0 the same cycle; all registers read 0 after release.
